// File: rtl/blit_pkg.sv
// Shared types and sizes for the blitter source walker and its pixel FIFO.
package blit_pkg;

    localparam int BLIT_ADDR_W    = 26;
    localparam int BLIT_DIM_W     = 12;
    localparam int PIX_FIFO_DEPTH = 4;
    localparam int PIX_CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } walk_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       eol;
        logic       eof;
    } pix_t;

endpackage

// File: rtl/blit_pix_fifo.sv
// Four-entry pixel FIFO with row/rectangle markers; synchronous flush, async reset.
module blit_pix_fifo
    import blit_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 push,
    input  pix_t                 push_data,
    input  logic                 pop,
    output pix_t                 pop_data,
    output logic [PIX_CNT_W-1:0] count,
    output logic                 empty
);

    pix_t       mem [PIX_FIFO_DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            count <= count + PIX_CNT_W'(push) - PIX_CNT_W'(pop);
        end
    end

    // NOTE: storage is deliberately not reset; the head is forced to zero while empty instead.
    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign empty    = (count == '0);
    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/blit_src_walker.sv
// Raster walker over a source rectangle: issues cache byte reads and streams the
// returned pixels, tagged with end-of-row/end-of-rectangle, to the pixel pipeline.
module blit_src_walker
    import blit_pkg::*;
#(
    parameter int ADDR_W = BLIT_ADDR_W,
    parameter int DIM_W  = BLIT_DIM_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [15:0]       cmd_stride,
    input  logic [DIM_W-1:0]  cmd_width,
    input  logic [DIM_W-1:0]  cmd_height,
    output logic [ADDR_W-1:0] read_address,
    output logic              read_request,
    input  logic [7:0]        read_data,
    input  logic              read_stall,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              out_eol,
    output logic              out_eof,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    walk_state_t          state;
    logic [ADDR_W-1:0]    row_addr;
    logic [15:0]          stride_q;
    logic [DIM_W-1:0]     width_q;
    logic [DIM_W-1:0]     height_q;
    logic [DIM_W-1:0]     x;
    logic [DIM_W-1:0]     y;
    logic                 inflight;
    logic                 inflight_eol;
    logic                 inflight_eof;

    logic [ADDR_W-1:0]    stride_ext;
    logic                 last_x;
    logic                 last_y;
    logic                 accept;
    logic                 pop;
    logic                 fifo_empty;
    logic [PIX_CNT_W-1:0] fifo_count;
    pix_t                 head;

    assign stride_ext   = {{(ADDR_W-16){stride_q[15]}}, stride_q};
    assign last_x       = (x == width_q - DIM_W'(1));
    assign last_y       = (y == height_q - DIM_W'(1));

    // At most two queued plus one in flight keeps the 4-deep FIFO from ever overflowing.
    assign read_request = (state == ISSUE) && ((fifo_count + PIX_CNT_W'(inflight)) <= PIX_CNT_W'(2));
    assign read_address = row_addr + ADDR_W'(x);
    assign accept       = read_request && !read_stall;

    assign cmd_ready    = (state == IDLE);
    assign busy         = (state != IDLE);

    assign out_valid    = !fifo_empty;
    assign out_data     = head.data;
    assign out_eol      = head.eol;
    assign out_eof      = head.eof;
    assign pop          = out_valid && out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            row_addr     <= '0;
            stride_q     <= '0;
            width_q      <= '0;
            height_q     <= '0;
            x            <= '0;
            y            <= '0;
            inflight     <= 1'b0;
            inflight_eol <= 1'b0;
            inflight_eof <= 1'b0;
            done         <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= accept;
            if (accept) begin
                inflight_eol <= last_x;
                inflight_eof <= last_x && last_y;
            end
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        row_addr <= cmd_base;
                        stride_q <= cmd_stride;
                        width_q  <= cmd_width;
                        height_q <= cmd_height;
                        x        <= '0;
                        y        <= '0;
                        if (cmd_width == '0 || cmd_height == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        if (last_x) begin
                            x        <= '0;
                            row_addr <= row_addr + stride_ext;
                            if (last_y) state <= DRAIN;
                            else        y     <= y + DIM_W'(1);
                        end else begin
                            x <= x + DIM_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty && !inflight) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    blit_pix_fifo u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (cmd_ready && cmd_valid),
        .push      (inflight),
        .push_data ('{data: read_data, eol: inflight_eol, eof: inflight_eof}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_blit_src_walker.sv
// Scoreboard bench for blit_src_walker: expected reads and pixels are queued per
// command; negedge monitors compare every accepted read and every consumed pixel.
module tb_blit_src_walker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [25:0] cmd_base = '0;
    logic [15:0] cmd_stride = '0;
    logic [11:0] cmd_width = '0;
    logic [11:0] cmd_height = '0;
    logic [25:0] read_address;
    logic        read_request;
    logic [7:0]  read_data = '0;
    logic        read_stall = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_eol;
    logic        out_eof;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_idx = 0;
    int stall_cnt = 0;
    int stall_seen = 0;
    int pop_cnt = 0;
    int first_pop = 0;
    int last_pop = 0;
    int done_seen = 0;
    int done_base = 0;
    int max_cnt = 0;
    bit stall_mode = 1'b0;
    bit toggle_mode = 1'b0;
    bit prev_stalled = 1'b0;
    logic [25:0] prev_addr = '0;

    logic [25:0] exp_addr_q[$];
    logic [9:0]  exp_pix_q[$];

    blit_src_walker dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_base     (cmd_base),
        .cmd_stride   (cmd_stride),
        .cmd_width    (cmd_width),
        .cmd_height   (cmd_height),
        .read_address (read_address),
        .read_request (read_request),
        .read_data    (read_data),
        .read_stall   (read_stall),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_eol      (out_eol),
        .out_eof      (out_eof),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] pix_byte(input logic [25:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cache model: byte returned the cycle after acceptance; scripted stalls and out_ready toggling.
    always @(posedge clock) begin
        cyc++;
        if (read_request && !read_stall) begin
            read_data <= pix_byte(read_address);
            acc_idx++;
            stall_cnt = 0;
        end
        #1;
        if (toggle_mode) out_ready = ~out_ready;
        read_stall = 1'b0;
        if (stall_mode && read_request && (acc_idx == 0 || acc_idx == 4) && stall_cnt < 5) begin
            read_stall = 1'b1;
            stall_cnt++;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (busy && int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
            if (prev_stalled) begin
                check("stall_hold_req", read_request, 1);
                check("stall_hold_addr", read_address, prev_addr);
            end
            prev_stalled = read_request && read_stall;
            prev_addr    = read_address;
            if (read_request && read_stall) stall_seen++;
            if (read_request && !read_stall) begin
                if (exp_addr_q.size() == 0) check("read_extra", exp_addr_q.size(), 1);
                else check("read_addr", read_address, exp_addr_q.pop_front());
            end
            if (out_valid && out_ready) begin
                if (exp_pix_q.size() == 0) check("pixel_extra", exp_pix_q.size(), 1);
                else check("pixel", {out_data, out_eol, out_eof}, exp_pix_q.pop_front());
                if (pop_cnt == 0) first_pop = cyc;
                last_pop = cyc;
                pop_cnt++;
            end
            if (done) done_seen++;
        end
    end

    task automatic push_row(input logic [25:0] start, input int w, input bit last_row);
        logic [25:0] a;
        for (int i = 0; i < w; i++) begin
            a = start + 26'(i);
            exp_addr_q.push_back(a);
            exp_pix_q.push_back({pix_byte(a), (i == w - 1), last_row && (i == w - 1)});
        end
    endtask

    task automatic issue_cmd(input logic [25:0] base, input logic [15:0] stride,
                             input logic [11:0] w, input logic [11:0] h);
        int t = 0;
        while (!cmd_ready && t < 200) begin
            @(posedge clock); #1;
            t++;
        end
        check("cmd_ready_before_cmd", cmd_ready, 1);
        acc_idx    = 0;
        stall_cnt  = 0;
        stall_seen = 0;
        pop_cnt    = 0;
        done_base  = done_seen;
        cmd_base   = base;
        cmd_stride = stride;
        cmd_width  = w;
        cmd_height = h;
        cmd_valid  = 1'b1;
        @(posedge clock); #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic finish_cmd(input int budget);
        int t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!done && t < budget);
        check("done_seen", done, 1);
        @(posedge clock); #1;
        check("cmd_ready_after_done", cmd_ready, 1);
        repeat (3) begin
            @(posedge clock); #1;
        end
        check("done_pulses", done_seen - done_base, 1);
        check("reads_left", exp_addr_q.size(), 0);
        check("pixels_left", exp_pix_q.size(), 0);
    endtask

    task automatic run_basic();
        push_row(26'h1000, 4, 1'b0);
        push_row(26'h1040, 4, 1'b1);
        issue_cmd(26'h1000, 16'd64, 12'd4, 12'd2);
        check("first_req_latency", read_request, 1);
        finish_cmd(100);
        check("basic_pixel_count", pop_cnt, 8);
        check("basic_back_to_back", last_pop - first_pop, 7);
    endtask

    initial begin
        #3;
        check("rst_read_request", read_request, 0);
        check("rst_read_address", read_address, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_eol", out_eol, 0);
        check("rst_out_eof", out_eof, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        run_basic();

        stall_mode = 1'b1;
        push_row(26'h1000, 4, 1'b0);
        push_row(26'h1040, 4, 1'b1);
        issue_cmd(26'h1000, 16'd64, 12'd4, 12'd2);
        finish_cmd(200);
        stall_mode = 1'b0;
        check("stall_pixel_count", pop_cnt, 8);
        check("stall_cycles", stall_seen, 10);

        push_row(26'h0000020, 2, 1'b0);
        push_row(26'h3FFFFE0, 2, 1'b1);
        issue_cmd(26'h0000020, 16'hFFC0, 12'd2, 12'd2);
        finish_cmd(100);
        check("wrap_pixel_count", pop_cnt, 4);

        issue_cmd(26'h0002000, 16'd64, 12'd0, 12'd5);
        @(negedge clock);
        check("zero_done_pulse", done, 1);
        @(negedge clock);
        check("zero_done_single", done, 0);
        check("zero_cmd_ready", cmd_ready, 1);
        repeat (3) @(posedge clock);
        #1;
        check("zero_done_count", done_seen - done_base, 1);
        check("zero_reads", acc_idx, 0);
        check("zero_pixels", pop_cnt, 0);

        max_cnt = 0;
        push_row(26'h0000300, 16, 1'b1);
        toggle_mode = 1'b1;
        issue_cmd(26'h0000300, 16'd0, 12'd16, 12'd1);
        finish_cmd(300);
        toggle_mode = 1'b0;
        out_ready   = 1'b1;
        check("toggle_pixel_count", pop_cnt, 16);
        check("toggle_fifo_max_le3", (max_cnt <= 3), 1);

        push_row(26'h0000500, 8, 1'b0);
        push_row(26'h0000520, 8, 1'b1);
        issue_cmd(26'h0000500, 16'd32, 12'd8, 12'd2);
        repeat (3) @(posedge clock);
        #2;
        check("pre_reset_busy", busy, 1);
        check("pre_reset_request", read_request, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_read_request", read_request, 0);
        check("mid_rst_read_address", read_address, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_eol", out_eol, 0);
        check("mid_rst_out_eof", out_eof, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        exp_addr_q.delete();
        exp_pix_q.delete();
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;

        run_basic();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
